serial_rx: RTL and testbench



---
 rtl/serial_rx_if.sv | 19 +
 rtl/serial_rx.sv | 212 +++++++++++++++++++++
 tb/tb_serial_rx.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_rx_if.sv
`default_nettype none
// ============================================================================
// Module   : serial_rx_if
// Brief    : Serial line, enable and received-byte signals of serial_rx.
// Revision : 1.0 - initial release
// ============================================================================
interface serial_rx_if;
   logic       en;
   logic       rx;
   logic [7:0] data_out;
   logic       valid;
   logic       busy;
   logic       frame_err;
   logic       parity_err;

   modport master (output en, rx, input data_out, valid, busy, frame_err, parity_err);
   modport slave  (input en, rx, output data_out, valid, busy, frame_err, parity_err);
endinterface
`default_nettype wire

// File: rtl/serial_rx.sv
`default_nettype none
// ============================================================================
// Module   : serial_rx
// Brief    : 8N1/8N2 UART receiver with its own oversampling tick; define
//            SERIAL_RX_PARITY_EN to add an even-parity bit after the data.
// Revision : 1.0 - initial release
// ============================================================================
module serial_rx #(
   parameter int CLK_FREQ      = 25_000_000,
   parameter int BAUD_RATE     = 115200,
   parameter int OVERSAMPLE    = 16,
   parameter int NUM_STOP_BITS = 1
) (
   input  wire logic  clk,
   input  wire logic  rst_n,
   serial_rx_if.slave bus
);
   localparam int c_DIV_RAW = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
   localparam int c_DIV     = (c_DIV_RAW < 1) ? 1 : c_DIV_RAW;
   localparam int c_DIV_W   = (c_DIV > 1) ? $clog2(c_DIV) : 1;
   localparam int c_TICK_W  = $clog2(OVERSAMPLE);
   localparam logic [c_DIV_W-1:0]  c_DIV_LAST  = c_DIV_W'(c_DIV - 1);
   localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(OVERSAMPLE - 1);
   localparam logic [c_TICK_W-1:0] c_TICK_HALF = c_TICK_W'(OVERSAMPLE / 2 - 1);
   localparam logic                c_STOP_LAST = 1'(NUM_STOP_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef SERIAL_RX_PARITY_EN
      ST_PARITY = 3'd5,
`endif
      ST_STOP   = 3'd3,
      ST_BREAK  = 3'd4
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_sync1;
   logic                  r_rx_s;
   logic [c_DIV_W-1:0]    r_div_cnt;
   logic [c_TICK_W-1:0]   r_tick_cnt;
   logic [2:0]            r_bit_cnt;
   logic                  r_stop_cnt;
   logic [7:0]            r_shift;
   logic [7:0]            r_data_out;
   logic                  r_valid;
   logic                  r_frame_err;
   logic                  r_parity_err;
   logic                  w_os_tick;
   logic                  w_half_done;
   logic                  w_bit_done;
   logic                  w_tick_wrap;
   logic                  w_par_bad;
   logic                  w_shift_en;
   logic                  w_stop_inc;
   logic                  w_load;
   logic                  w_valid_nxt;
   logic                  w_ferr_nxt;
   logic                  w_perr_nxt;

   assign w_os_tick   = (r_state != ST_IDLE) && (r_div_cnt == c_DIV_LAST);
   assign w_half_done = w_os_tick && (r_tick_cnt == c_TICK_HALF);
   assign w_bit_done  = w_os_tick && (r_tick_cnt == c_TICK_LAST);
   assign w_tick_wrap = (r_state == ST_START) ? w_half_done : w_bit_done;

`ifdef SERIAL_RX_PARITY_EN
   logic r_par_bit;
   logic w_par_ld;
   assign w_par_bad = ^{r_shift, r_par_bit};
`else
   assign w_par_bad = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_shift_en  = 1'b0;
      w_stop_inc  = 1'b0;
      w_load      = 1'b0;
      w_valid_nxt = 1'b0;
      w_ferr_nxt  = 1'b0;
      w_perr_nxt  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      w_par_ld    = 1'b0;
`endif
      case (r_state)
         ST_IDLE: begin
            if (bus.en && !r_rx_s) w_state_nxt = ST_START;
         end
         ST_START: begin
            if (w_half_done) w_state_nxt = r_rx_s ? ST_IDLE : ST_DATA;
         end
         ST_DATA: begin
            if (w_bit_done) begin
               w_shift_en = 1'b1;
               if (r_bit_cnt == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
                  w_state_nxt = ST_PARITY;
`else
                  w_state_nxt = ST_STOP;
`endif
               end
            end
         end
`ifdef SERIAL_RX_PARITY_EN
         ST_PARITY: begin
            if (w_bit_done) begin
               w_par_ld    = 1'b1;
               w_state_nxt = ST_STOP;
            end
         end
`endif
         ST_STOP: begin
            if (w_bit_done) begin
               if (!r_rx_s) begin
                  w_load      = 1'b1;
                  w_ferr_nxt  = 1'b1;
                  w_perr_nxt  = w_par_bad;
                  w_state_nxt = ST_BREAK;
               end else if (r_stop_cnt == c_STOP_LAST) begin
                  w_load      = 1'b1;
                  w_valid_nxt = !w_par_bad;
                  w_perr_nxt  = w_par_bad;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_stop_inc  = 1'b1;
               end
            end
         end
         ST_BREAK: begin
            // A held-low line must rise before a new start bit can be seen
            if (r_rx_s) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if ((r_state != ST_IDLE) && !bus.en) begin
         w_state_nxt = ST_IDLE;
         w_shift_en  = 1'b0;
         w_stop_inc  = 1'b0;
         w_load      = 1'b0;
         w_valid_nxt = 1'b0;
         w_ferr_nxt  = 1'b0;
         w_perr_nxt  = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
         w_par_ld    = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1      <= 1'b1;
         r_rx_s       <= 1'b1;
         r_div_cnt    <= '0;
         r_tick_cnt   <= '0;
         r_bit_cnt    <= 3'd0;
         r_stop_cnt   <= 1'b0;
         r_shift      <= 8'h00;
         r_data_out   <= 8'h00;
         r_valid      <= 1'b0;
         r_frame_err  <= 1'b0;
         r_parity_err <= 1'b0;
      end else begin
         r_sync1      <= bus.rx;
         r_rx_s       <= r_sync1;
         r_valid      <= w_valid_nxt;
         r_frame_err  <= w_ferr_nxt;
         r_parity_err <= w_perr_nxt;
         if (w_load) r_data_out <= r_shift;
         if (w_shift_en) r_shift <= {r_rx_s, r_shift[7:1]};
         // Ticks restart from zero on every start so they stay edge-aligned
         if (r_state == ST_IDLE) begin
            r_div_cnt  <= '0;
            r_tick_cnt <= '0;
            r_bit_cnt  <= 3'd0;
            r_stop_cnt <= 1'b0;
         end else begin
            r_div_cnt <= (r_div_cnt == c_DIV_LAST) ? '0 : r_div_cnt + 1'b1;
            if (w_tick_wrap) r_tick_cnt <= '0;
            else if (w_os_tick) r_tick_cnt <= r_tick_cnt + 1'b1;
            if (w_shift_en) r_bit_cnt <= r_bit_cnt + 3'd1;
            if (w_stop_inc) r_stop_cnt <= r_stop_cnt + 1'b1;
         end
      end
   end

`ifdef SERIAL_RX_PARITY_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_par_bit <= 1'b0;
      end else if (w_par_ld) begin
         r_par_bit <= r_rx_s;
      end
   end
`endif

   assign bus.data_out   = r_data_out;
   assign bus.valid      = r_valid;
   assign bus.busy       = (r_state != ST_IDLE);
   assign bus.frame_err  = r_frame_err;
   assign bus.parity_err = r_parity_err;
endmodule
`default_nettype wire

// File: tb/tb_serial_rx.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_rx
// Brief    : Directed self-checking bench for serial_rx (DIV=10, 160 clk/bit).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_rx;
   localparam int c_BIT = 160;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   serial_rx_if u_if ();

   serial_rx #(
      .CLK_FREQ      (18_432_000),
      .BAUD_RATE     (115200),
      .OVERSAMPLE    (16),
      .NUM_STOP_BITS (1)
   ) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   int   cyc = 0, v_cnt = 0, fe_cnt = 0, pe_cnt = 0, busy_starts = 0;
   int   busy_run = 0, last_busy_len = 0, busy_fall_cyc = 0;
   int   long_pulse = 0, overlap = 0;
   logic prev_v = 1'b0, prev_fe = 1'b0, prev_pe = 1'b0, prev_busy = 1'b0;
   logic [7:0] q_data[$];
   int         q_vcyc[$];

   always @(negedge clk) begin
      cyc     <= cyc + 1;
      prev_v  <= u_if.valid;
      prev_fe <= u_if.frame_err;
      prev_pe <= u_if.parity_err;
      prev_busy <= u_if.busy;
      if (u_if.valid === 1'b1) begin
         v_cnt <= v_cnt + 1;
         q_data.push_back(u_if.data_out);
         q_vcyc.push_back(cyc);
      end
      if (u_if.frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
      if (u_if.parity_err === 1'b1) pe_cnt <= pe_cnt + 1;
      if ((u_if.valid && prev_v) || (u_if.frame_err && prev_fe) || (u_if.parity_err && prev_pe))
         long_pulse <= long_pulse + 1;
      if (u_if.valid && u_if.frame_err) overlap <= overlap + 1;
      if (u_if.busy && !prev_busy) begin
         busy_starts <= busy_starts + 1;
         busy_run    <= 1;
      end else if (u_if.busy) begin
         busy_run <= busy_run + 1;
      end
      if (!u_if.busy && prev_busy) begin
         last_busy_len <= busy_run;
         busy_fall_cyc <= cyc;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic send_bit(input logic b);
      u_if.rx = b;
      idle(c_BIT);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic stop_lvl,
                             input logic has_par, input logic par);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(d[i]);
      if (has_par) send_bit(par);
      send_bit(stop_lvl);
   endtask

   function automatic logic [7:0] q_at(input int idx);
      return (idx >= 0 && idx < q_data.size()) ? q_data[idx] : 8'hxx;
   endfunction

   function automatic int vcyc_at(input int idx);
      return (idx >= 0 && idx < q_vcyc.size()) ? q_vcyc[idx] : -100000;
   endfunction

   initial begin
      int nv, nf, np, nb, nq, t0;
      u_if.en = 1'b1;
      u_if.rx = 1'b1;
      idle(3);
      #1;
      check("rst_data_out",   u_if.data_out,   8'h00);
      check("rst_valid",      u_if.valid,      1'b0);
      check("rst_busy",       u_if.busy,       1'b0);
      check("rst_frame_err",  u_if.frame_err,  1'b0);
      check("rst_parity_err", u_if.parity_err, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(20);

      // A5 8N1
      nv = v_cnt; nf = fe_cnt; nq = q_data.size();
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
      idle(50);
      #1;
      check("t1_valid_cnt", v_cnt - nv, 1);
      check("t1_q_data",    q_at(nq), 8'hA5);
      check("t1_data_out",  u_if.data_out, 8'hA5);
      check("t1_ferr_cnt",  fe_cnt - nf, 0);
      check("t1_busy_len",  (last_busy_len >= 1515 && last_busy_len <= 1525), 1);

      // 00 then FF back to back
      nv = v_cnt; nq = q_data.size();
      send_frame(8'h00, 1'b1, 1'b0, 1'b0);
      send_frame(8'hFF, 1'b1, 1'b0, 1'b0);
      idle(50);
      #1;
      check("t2_valid_cnt", v_cnt - nv, 2);
      check("t2_first",     q_at(nq), 8'h00);
      check("t2_second",    q_at(nq + 1), 8'hFF);
      check("t2_gap",       vcyc_at(nq + 1) - vcyc_at(nq), 1600);

      // 60-clk glitch
      nv = v_cnt; nf = fe_cnt; nb = busy_starts;
      @(negedge clk);
      u_if.rx = 1'b0;
      #1;
      t0 = cyc;
      idle(60);
      u_if.rx = 1'b1;
      idle(150);
      #1;
      check("t3_busy_start", busy_starts - nb, 1);
      check("t3_no_strobe",  (v_cnt - nv) + (fe_cnt - nf), 0);
      check("t3_busy_fall",  (busy_fall_cyc - t0 >= 78 && busy_fall_cyc - t0 <= 85), 1);

      // 3C with low stop bit, then break
      nv = v_cnt; nf = fe_cnt; nb = busy_starts;
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      idle(2000);
      #1;
      check("t4_busy_in_break", u_if.busy, 1'b1);
      @(negedge clk);
      u_if.rx = 1'b1;
      idle(6);
      #1;
      check("t4_busy_after", u_if.busy, 1'b0);
      idle(400);
      #1;
      check("t4_ferr_cnt",    fe_cnt - nf, 1);
      check("t4_valid_cnt",   v_cnt - nv, 0);
      check("t4_data_out",    u_if.data_out, 8'h3C);
      check("t4_busy_starts", busy_starts - nb, 1);

      // en dropped for one clk in the middle of data bit 2
      nv = v_cnt; nf = fe_cnt; nb = busy_starts;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b1);
      u_if.rx = 1'b1;
      idle(80);
      u_if.en = 1'b0;
      idle(1);
      u_if.en = 1'b1;
      idle(79);
      for (int i = 3; i < 9; i++) send_bit(1'b1);
      idle(50);
      #1;
      check("t5_abort_valid", v_cnt - nv, 0);
      check("t5_abort_ferr",  fe_cnt - nf, 0);
      check("t5_abort_data",  u_if.data_out, 8'h3C);
      check("t5_abort_busy",  u_if.busy, 1'b0);
      check("t5_abort_start", busy_starts - nb, 1);

      // reset asserted mid-frame
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(1'b0);
      u_if.rx = 1'b0;
      idle(80);
      check("t5_pre_rst_busy", u_if.busy, 1'b1);
      rst_n = 1'b0;
      #1;
      check("t5_rst_busy", u_if.busy, 1'b0);
      check("t5_rst_data", u_if.data_out, 8'h00);
      check("t5_rst_valid", u_if.valid, 1'b0);
      idle(80);
      for (int i = 5; i < 8; i++) send_bit(1'b0);
      send_bit(1'b1);
      #1;
      check("t5_rst_hold_busy", u_if.busy, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(20);
      nv = v_cnt; nq = q_data.size();
      send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
      idle(50);
      #1;
      check("t5_valid_cnt", v_cnt - nv, 1);
      check("t5_q_data",    q_at(nq), 8'h5A);
      check("t5_data_out",  u_if.data_out, 8'h5A);

`ifdef SERIAL_RX_PARITY_EN
      nv = v_cnt; np = pe_cnt; nq = q_data.size();
      send_frame(8'h07, 1'b1, 1'b1, 1'b1);
      idle(50);
      #1;
      check("t6_good_valid", v_cnt - nv, 1);
      check("t6_good_data",  q_at(nq), 8'h07);
      check("t6_good_perr",  pe_cnt - np, 0);
      nv = v_cnt; np = pe_cnt;
      send_frame(8'h07, 1'b1, 1'b1, 1'b0);
      idle(50);
      #1;
      check("t6_bad_perr",  pe_cnt - np, 1);
      check("t6_bad_valid", v_cnt - nv, 0);
      check("t6_bad_data",  u_if.data_out, 8'h07);
`else
      np = 0;
      check("no_parity_err", pe_cnt - np, 0);
`endif

      check("pulse_width_1clk",   long_pulse, 0);
      check("valid_ferr_overlap", overlap, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
